key_entry_accumulator: RTL and testbench
========================================

// Module: key_entry_accumulator
// PURPOSE
//   Parametrised successor to the keypad adder: builds multi-digit operands from debounced 4x4 keypad codes.
//   Adds committed operands into a running total, with clear keys, overflow tracking and a result strobe.
//   Sits between the keypad scanner/debouncer and the 7-segment display driver.
// PARAMETERS
//   ACC_W       12  width of entry and total registers (bits)
//   MAX_DIGITS  3   max digits per operand; further digit keys ignored
//   BASE        10  digit radix; digits accepted are 0..BASE-1
//   Elaboration check: BASE**MAX_DIGITS-1 must be <= 2**ACC_W-1, else $error (entry can never overflow).
// PORTS
//   clk           in   1       system clock
//   rst           in   1       async reset, active-high
//   key_value     in   4       keypad code, valid while key_pressed=1
//   key_pressed   in   1       debounced, synchronous key-down level
//   entry         out  ACC_W   operand being typed
//   digit_cnt     out  $clog2(MAX_DIGITS+1)  digits in entry
//   total         out  ACC_W   running total
//   result_valid  out  1       1-cycle strobe when ENTER commits
//   overflow      out  1       sticky: any total addition exceeded 2**ACC_W-1
//   state_o       out  2       FSM state for debug/display
// BEHAVIOUR
//   - Reset (async, rst=1): entry=0, digit_cnt=0, total=0, result_valid=0, overflow=0, state=S_IDLE, key_prev=1.
//   - Event = key_pressed & ~key_prev. key_prev resets to 1: a key held through reset release fires nothing.
//   - One event per press; key_value is sampled on the event cycle. All outputs update at that same clock edge.
//   - Keys:
//     - digit d < BASE: if digit_cnt<MAX_DIGITS then entry<=entry*BASE+d, digit_cnt++, else ignored. ->S_ENTRY.
//     - KEY_ADD (A): if digit_cnt>0 then total<=total+entry. entry<=0, cnt<=0. ->S_IDLE.
//     - KEY_ENTER (F): same add as KEY_ADD, result_valid=1 for exactly one cycle. ->S_DONE.
//       Fires even when digit_cnt==0 (strobe with unchanged total).
//     - KEY_CLR_ENTRY (E): entry<=0, cnt<=0, total kept. ->S_IDLE if total==0 else stays.
//     - KEY_CLR_ALL (C): entry, cnt, total, overflow <= 0. ->S_IDLE.
//     - Digits >=BASE, B, D: ignored, no state change.
//   - FSM states:
//     - S_IDLE (no pending entry); S_ENTRY (cnt>0); S_DONE (result shown).
//     - Digit in S_DONE starts a new entry; total is kept.
//   - Arithmetic: sum computed ACC_W+1 wide; carry-out sets overflow (sticky until C or rst).
//   - Reset mid-entry clears everything immediately; no partial commit.
// CONFIGURATION
//   - KEY_ACC_SATURATE_EN defined: on carry-out, total <= {ACC_W{1'b1}} and holds there on further adds until cleared.
//   - Not defined: total wraps modulo 2**ACC_W; overflow flag behaves identically in both cases.
// STRUCTURE
//   - Package key_acc_pkg:
//     - key code localparams KEY_ADD=4'hA, KEY_CLR_ALL=4'hC, KEY_CLR_ENTRY=4'hE, KEY_ENTER=4'hF.
//     - state enum {S_IDLE, S_ENTRY, S_DONE}.
//   - Sub-module key_edge_detect (key_pressed -> 1-cycle event, reset-to-1 prev register).
//   - Remaining FSM, datapath and saturation mux live in this module.
// TESTING
//   1. Keys 1,2,3 then F -> entry=123 after 3rd press; then total=123, entry=0, result_valid high exactly 1 cycle.
//   2. Keys 1,2,3,4 -> entry=123, digit_cnt=3 (4th ignored); E -> entry=0, total unchanged.
//   3. Five times (9,9,9,A) -> overflow=1 on 5th add (4995>4095).
//      With KEY_ACC_SATURATE_EN: total=4095. Without: total=899. Then C -> total=0, overflow=0.
//   4. Key held across rst release, then held 10 cycles -> no event; release+press '5' -> entry=5, one event only.
//   5. rst pulsed mid-entry (entry=12) -> all outputs 0 immediately, before next clk edge.
//   6. After F (S_DONE, total=123), keys 7,A -> total=130, state S_IDLE; keys B, D -> no change.

Source files
------------

// File: rtl/key_entry_accumulator_pkg.sv
// key_acc_pkg: shared keypad command codes and FSM state encoding for the
// key entry accumulator slice.
package key_acc_pkg;

  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_CLR_ALL   = 4'hC;
  localparam logic [3:0] KEY_CLR_ENTRY = 4'hE;
  localparam logic [3:0] KEY_ENTER     = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/key_entry_accumulator_edge.sv
// key_edge_detect: turns the debounced key-down level into a one-cycle event.
// Ports:
//   clk, rst     clock, async active-high reset
//   key_pressed  debounced key-down level
//   key_event    high for the first cycle of each press
// The previous-level register resets to 1 so a key held through reset
// release produces no event until it is released and pressed again.
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key_pressed,
  output logic key_event
);

  logic key_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_prev <= 1'b1;
    else     key_prev <= key_pressed;
  end

  assign key_event = key_pressed & ~key_prev;

endmodule

// File: rtl/key_entry_accumulator.sv
// key_entry_accumulator: builds multi-digit operands from keypad codes and
// adds committed operands into a running total.
// Ports:
//   clk, rst      clock, async active-high reset
//   key_value     keypad code, valid while key_pressed=1
//   key_pressed   debounced key-down level
//   entry         operand being typed
//   digit_cnt     digits currently in entry
//   total         running total
//   result_valid  one-cycle strobe on ENTER
//   overflow      sticky carry-out of any total addition
//   state_o       FSM state for debug/display
// Build option: define KEY_ACC_SATURATE_EN to clamp total at all-ones on
// carry-out instead of wrapping.
module key_entry_accumulator
  import key_acc_pkg::*;
#(
  parameter int ACC_W      = 12,
  parameter int MAX_DIGITS = 3,
  parameter int BASE       = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        key_value,
  input  logic                              key_pressed,
  output logic [ACC_W-1:0]                  entry,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
  output logic [ACC_W-1:0]                  total,
  output logic                              result_valid,
  output logic                              overflow,
  output logic [1:0]                        state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS+1);

  if (BASE**MAX_DIGITS - 1 > 2**ACC_W - 1) begin : g_range_chk
    $error("key_entry_accumulator: BASE**MAX_DIGITS-1 does not fit in ACC_W bits");
  end

  state_t           state;
  logic             key_event;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_total;

  key_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .key_pressed(key_pressed),
    .key_event  (key_event)
  );

  always_comb begin
    sum       = {1'b0, total} + {1'b0, entry};
    sum_total = sum[ACC_W-1:0];
`ifdef KEY_ACC_SATURATE_EN
    if (sum[ACC_W]) sum_total = '1;
`else
    sum_total = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry        <= '0;
      digit_cnt    <= '0;
      total        <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      state        <= S_IDLE;
    end else begin
      result_valid <= 1'b0;
      if (key_event) begin
        case (key_value)
          KEY_ADD, KEY_ENTER: begin
            // An empty entry commits nothing, but ENTER still strobes.
            if (digit_cnt != '0) begin
              total <= sum_total;
              if (sum[ACC_W]) overflow <= 1'b1;
            end
            entry     <= '0;
            digit_cnt <= '0;
            if (key_value == KEY_ENTER) begin
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end
          KEY_CLR_ENTRY: begin
            entry     <= '0;
            digit_cnt <= '0;
            if (total == '0) state <= S_IDLE;
          end
          KEY_CLR_ALL: begin
            entry     <= '0;
            digit_cnt <= '0;
            total     <= '0;
            overflow  <= 1'b0;
            state     <= S_IDLE;
          end
          default: begin
            if (int'(key_value) < BASE) begin
              if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                entry     <= entry * ACC_W'(BASE) + ACC_W'(key_value);
                digit_cnt <= digit_cnt + 1'b1;
              end
              state <= S_ENTRY;
            end
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_key_entry_accumulator.sv
module tb_key_entry_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_value;
  logic        key_pressed;
  logic [11:0] entry;
  logic [1:0]  digit_cnt;
  logic [11:0] total;
  logic        result_valid;
  logic        overflow;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] SI = 2'd0, SE = 2'd1, SD = 2'd2;

  typedef struct {
    logic [3:0]  key;
    logic [11:0] entry;
    logic [1:0]  cnt;
    logic [11:0] total;
    logic        rv;
    logic        ovf;
    logic [1:0]  st;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];

  key_entry_accumulator #(.ACC_W(12), .MAX_DIGITS(3), .BASE(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_value   (key_value),
    .key_pressed (key_pressed),
    .entry       (entry),
    .digit_cnt   (digit_cnt),
    .total       (total),
    .result_valid(result_valid),
    .overflow    (overflow),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] k, input int e, input int c,
                              input int t, input logic rv, input logic ovf,
                              input logic [1:0] st);
    vec_t v;
    v.key = k; v.entry = 12'(e); v.cnt = 2'(c); v.total = 12'(t);
    v.rv = rv; v.ovf = ovf; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_pop();
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      checks--;
      e = sb.pop_front();
      chk("entry",        int'(entry),        int'(e.entry));
      chk("digit_cnt",    int'(digit_cnt),    int'(e.cnt));
      chk("total",        int'(total),        int'(e.total));
      chk("result_valid", int'(result_valid), int'(e.rv));
      chk("overflow",     int'(overflow),     int'(e.ovf));
      chk("state",        int'(state_o),      int'(e.st));
    end
  endtask

  task automatic press(input vec_t e);
    @(negedge clk);
    key_value   = e.key;
    key_pressed = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    compare_pop();
    @(negedge clk);
    key_pressed = 1'b0;
    @(posedge clk); #1;
    chk("rv_one_cycle", int'(result_valid), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_entry"},  int'(entry),        0);
    chk({tag, "_cnt"},    int'(digit_cnt),    0);
    chk({tag, "_total"},  int'(total),        0);
    chk({tag, "_rv"},     int'(result_valid), 0);
    chk({tag, "_ovf"},    int'(overflow),     0);
    chk({tag, "_state"},  int'(state_o),      0);
  endtask

  int tm;
  int om;
  int s;

  initial begin
    rst = 1'b1; key_value = 4'h0; key_pressed = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // entry, ENTER strobe, digit limit, ignored keys, clears
    tbl[0]  = mk(4'h1, 1,   1, 0,   0, 0, SE);
    tbl[1]  = mk(4'h2, 12,  2, 0,   0, 0, SE);
    tbl[2]  = mk(4'h3, 123, 3, 0,   0, 0, SE);
    tbl[3]  = mk(4'hF, 0,   0, 123, 1, 0, SD);
    tbl[4]  = mk(4'h7, 7,   1, 123, 0, 0, SE);
    tbl[5]  = mk(4'hA, 0,   0, 130, 0, 0, SI);
    tbl[6]  = mk(4'hB, 0,   0, 130, 0, 0, SI);
    tbl[7]  = mk(4'hD, 0,   0, 130, 0, 0, SI);
    tbl[8]  = mk(4'h1, 1,   1, 130, 0, 0, SE);
    tbl[9]  = mk(4'h2, 12,  2, 130, 0, 0, SE);
    tbl[10] = mk(4'h3, 123, 3, 130, 0, 0, SE);
    tbl[11] = mk(4'h4, 123, 3, 130, 0, 0, SE);
    tbl[12] = mk(4'hE, 0,   0, 130, 0, 0, SE);
    tbl[13] = mk(4'hC, 0,   0, 0,   0, 0, SI);
    tbl[14] = mk(4'hF, 0,   0, 0,   1, 0, SD);
    tbl[15] = mk(4'hE, 0,   0, 0,   0, 0, SI);
    tbl[16] = mk(4'h0, 0,   1, 0,   0, 0, SE);
    tbl[17] = mk(4'hA, 0,   0, 0,   0, 0, SI);
    for (int i = 0; i < 18; i++) press(tbl[i]);

    // overflow: five additions of 999 into a 12-bit total
    press(mk(4'hC, 0, 0, 0, 0, 0, SI));
    tm = 0; om = 0;
    for (int r = 0; r < 5; r++) begin
      press(mk(4'h9, 9,   1, tm, 0, om[0], SE));
      press(mk(4'h9, 99,  2, tm, 0, om[0], SE));
      press(mk(4'h9, 999, 3, tm, 0, om[0], SE));
      s = tm + 999;
      if (s > 4095) om = 1;
`ifdef KEY_ACC_SATURATE_EN
      tm = (s > 4095) ? 4095 : s;
`else
      tm = s % 4096;
`endif
      press(mk(4'hA, 0, 0, tm, 0, om[0], SI));
    end
`ifdef KEY_ACC_SATURATE_EN
    chk("ovf_total", tm, 4095);
`else
    chk("ovf_total", int'(total), 899);
`endif
    press(mk(4'hC, 0, 0, 0, 0, 0, SI));

    // async reset mid-entry
    press(mk(4'h1, 1,  1, 0, 0, 0, SE));
    press(mk(4'h2, 12, 2, 0, 0, 0, SE));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk) rst = 1'b0;

    // key held through reset release fires nothing
    @(negedge clk);
    key_value = 4'h5; key_pressed = 1'b1; rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk_all_zero("held_key");
    @(negedge clk) key_pressed = 1'b0;
    @(negedge clk) key_pressed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("repress_entry", int'(entry),     5);
    chk("repress_cnt",   int'(digit_cnt), 1);
    chk("repress_state", int'(state_o),   int'(SE));
    @(negedge clk) key_pressed = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
